// File: rtl/ys_poly_small_pkg.sv
`default_nettype none
// ============================================================================
// ys_poly_small_pkg : shared mode/state encodings and default widths
// Rev 1.0
// ============================================================================
package ys_poly_small_pkg;

  localparam int c_DEF_CW    = 13;
  localparam int c_DEF_LANES = 4;

  typedef enum logic [1:0] {
    MODE_COPY  = 2'd0,
    MODE_NEG   = 2'd1,
    MODE_DIFF  = 2'd2,
    MODE_DIFF3 = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage : ys_poly_small_pkg
`default_nettype wire

// File: rtl/ys_poly_small_lane_op.sv
`default_nettype none
// ============================================================================
// ys_poly_small_lane_op : combinational transform of one coefficient
// Rev 1.0
// ============================================================================
module ys_poly_small_lane_op
  import ys_poly_small_pkg::*;
#(
  parameter int CW = c_DEF_CW
) (
  input  logic [CW-1:0] c,
  input  logic [CW-1:0] p,
  input  logic [1:0]    mode,
  output logic [CW-1:0] result
);

  logic [CW-1:0] w_d;
  logic [CW-1:0] w_d2;

  assign w_d  = p - c;
  assign w_d2 = w_d << 1;

  always_comb begin
    result = c;
    case (mode)
      MODE_COPY:  result = c;
      MODE_NEG:   result = '0 - c;
      MODE_DIFF:  result = w_d;
      MODE_DIFF3: result = w_d + w_d2;
      default:    result = c;
    endcase
  end

endmodule : ys_poly_small_lane_op
`default_nettype wire

// File: rtl/ys_poly_small_stream.sv
`default_nettype none
// ============================================================================
// ys_poly_small_stream : RAM1 -> per-lane transform -> RAM2, one word/cycle
// Optional cycle counter port enabled by YS_POLY_SMALL_CYCCNT_EN.  Rev 1.0
// ============================================================================
module ys_poly_small_stream
  import ys_poly_small_pkg::*;
#(
  parameter int LANES = c_DEF_LANES,
  parameter int CW    = c_DEF_CW,
  parameter int WORDS = 128,
  parameter int AW    = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            mode,
  output logic                  busy,
  output logic                  done,
  output logic                  ram1_en,
  output logic [AW-1:0]         ram1_addr,
  input  logic [LANES*CW-1:0]   ram1_dout,
  output logic                  ram2_we,
  output logic [AW-1:0]         ram2_addr,
`ifdef YS_POLY_SMALL_CYCCNT_EN
  output logic [15:0]           cyc_cnt,
`endif
  output logic [LANES*CW-1:0]   ram2_din
);

  localparam logic [AW-1:0] c_LAST = AW'(WORDS - 1);

  state_e                r_state;
  state_e                w_next;
  logic                  w_start_acc;
  logic [1:0]            r_mode;
  logic [AW-1:0]         r_rd_addr;
  logic                  r_vld;
  logic [AW-1:0]         r_vaddr;
  logic [CW-1:0]         r_carry;
  logic                  r_we;
  logic [AW-1:0]         r_waddr;
  logic [LANES*CW-1:0]   r_din;
  logic [LANES*CW-1:0]   w_res;
  logic [CW-1:0]         w_c [LANES];
  logic [CW-1:0]         w_p [LANES];

  assign w_start_acc = (r_state == ST_IDLE) && start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    busy      = 1'b0;
    done      = 1'b0;
    ram1_en   = 1'b0;
    ram1_addr = '0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next = ST_READ;
      end
      ST_READ: begin
        busy      = 1'b1;
        ram1_en   = 1'b1;
        ram1_addr = r_rd_addr;
        if (r_rd_addr == c_LAST) w_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        // Leave once the write for the final word is on the RAM2 port.
        if (r_we && (r_waddr == c_LAST)) w_next = ST_DONE;
      end
      ST_DONE: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode    <= '0;
      r_rd_addr <= '0;
      r_vld     <= 1'b0;
      r_vaddr   <= '0;
    end else begin
      if (w_start_acc) begin
        r_mode    <= mode;
        r_rd_addr <= '0;
      end else if (r_state == ST_READ) begin
        r_rd_addr <= r_rd_addr + 1'b1;
      end
      r_vld   <= (r_state == ST_READ);
      r_vaddr <= r_rd_addr;
    end
  end

  generate
    for (genvar k = 0; k < LANES; k++) begin : g_lane
      assign w_c[k] = ram1_dout[k*CW +: CW];
      if (k == 0) begin : g_first
        assign w_p[k] = r_carry;
      end else begin : g_rest
        assign w_p[k] = w_c[k-1];
      end
      ys_poly_small_lane_op #(
        .CW (CW)
      ) u_op (
        .c      (w_c[k]),
        .p      (w_p[k]),
        .mode   (r_mode),
        .result (w_res[k*CW +: CW])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_din   <= '0;
      r_carry <= '0;
    end else begin
      r_we <= r_vld;
      if (r_vld) begin
        r_waddr <= r_vaddr;
        r_din   <= w_res;
      end
      if (w_start_acc) begin
        r_carry <= '0;
      end else if (r_vld) begin
        r_carry <= w_c[LANES-1];
      end
    end
  end

  assign ram2_we   = r_we;
  assign ram2_addr = r_waddr;
  assign ram2_din  = r_din;

`ifdef YS_POLY_SMALL_CYCCNT_EN
  logic [15:0] r_cyc_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cyc_cnt <= '0;
    end else if (w_start_acc) begin
      r_cyc_cnt <= '0;
    end else if (busy) begin
      r_cyc_cnt <= r_cyc_cnt + 16'd1;
    end
  end

  assign cyc_cnt = r_cyc_cnt;
`else
  // Cycle counter not built in this configuration.
`endif

endmodule : ys_poly_small_stream
`default_nettype wire

// File: tb/tb_ys_poly_small_stream.sv
`default_nettype none
// ============================================================================
// tb_ys_poly_small_stream : directed bench, WORDS=2 and WORDS=1 instances
// Rev 1.0
// ============================================================================
module tb_ys_poly_small_stream;

  localparam int LN = 4;
  localparam int CWT = 13;
  localparam int W0 = 2;
  localparam int W1 = 1;
  localparam int NC = LN * W0;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [1:0]       mode;

  logic             b0, d0, e0, we0;
  logic [6:0]       a10, a20;
  logic [LN*CWT-1:0] dout0, din0;
  logic             b1, d1, e1, we1;
  logic [6:0]       a11, a21;
  logic [LN*CWT-1:0] dout1, din1;
`ifdef YS_POLY_SMALL_CYCCNT_EN
  logic [15:0]      cnt0, cnt1;
`endif

  int               checks = 0;
  int               failures = 0;
  logic [CWT-1:0]   coef [NC];
  logic [LN*CWT-1:0] cap [W0];

  ys_poly_small_stream #(.LANES(LN), .CW(CWT), .WORDS(W0), .AW(7)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .busy(b0), .done(d0), .ram1_en(e0), .ram1_addr(a10), .ram1_dout(dout0),
    .ram2_we(we0), .ram2_addr(a20),
`ifdef YS_POLY_SMALL_CYCCNT_EN
    .cyc_cnt(cnt0),
`endif
    .ram2_din(din0)
  );

  ys_poly_small_stream #(.LANES(LN), .CW(CWT), .WORDS(W1), .AW(7)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .busy(b1), .done(d1), .ram1_en(e1), .ram1_addr(a11), .ram1_dout(dout1),
    .ram2_we(we1), .ram2_addr(a21),
`ifdef YS_POLY_SMALL_CYCCNT_EN
    .cyc_cnt(cnt1),
`endif
    .ram2_din(din1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [LN*CWT-1:0] pack_word(input int a);
    logic [LN*CWT-1:0] w;
    w = '0;
    for (int k = 0; k < LN; k++) w[k*CWT +: CWT] = coef[a*LN + k];
    return w;
  endfunction

  // Synchronous-read RAM1 models
  always @(posedge clk) begin
    if (e0) dout0 <= pack_word(int'(a10));
    if (e1) dout1 <= pack_word(int'(a11));
  end

  // Reference: each coefficient from its predecessor in the flat sequence
  function automatic logic [LN*CWT-1:0] exp_word(input int m, input int a);
    logic [LN*CWT-1:0] w;
    int i, p, c, r;
    w = '0;
    for (int k = 0; k < LN; k++) begin
      i = a * LN + k;
      c = int'(coef[i]);
      p = (i == 0) ? 0 : int'(coef[i-1]);
      case (m)
        0: r = c;
        1: r = -c;
        2: r = p - c;
        default: r = 3 * (p - c);
      endcase
      w[k*CWT +: CWT] = CWT'(r & 32'h1FFF);
    end
    return w;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic check_dut(input string tag, input int c, input int w, input int m,
                           input logic en, input logic [6:0] a1, input logic we,
                           input logic [6:0] a2, input logic [LN*CWT-1:0] din,
                           input logic bz, input logic dn);
    chk({tag, "_ram1_en"}, 64'(en), 64'(c >= 1 && c <= w));
    if (c >= 1 && c <= w) chk({tag, "_ram1_addr"}, 64'(a1), 64'(c - 1));
    chk({tag, "_ram2_we"}, 64'(we), 64'(c >= 3 && c <= w + 2));
    if (c >= 3 && c <= w + 2) begin
      chk({tag, "_ram2_addr"}, 64'(a2), 64'(c - 3));
      chk({tag, "_ram2_din"}, 64'(din), 64'(exp_word(m, c - 3)));
    end
    chk({tag, "_busy"}, 64'(bz), 64'(c >= 1 && c <= w + 3));
    chk({tag, "_done"}, 64'(dn), 64'(c == w + 3));
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_d0_outs"}, 64'({b0, d0, e0, a10, we0, a20}), 64'd0);
    chk({tag, "_d0_din"}, 64'(din0), 64'd0);
    chk({tag, "_d1_outs"}, 64'({b1, d1, e1, a11, we1, a21}), 64'd0);
    chk({tag, "_d1_din"}, 64'(din1), 64'd0);
  endtask

  // One run: start at edge T, then compare every cycle T+1..T+9.
  // c2>0 pulses a second start with mode m2; abort_c>0 drops rst_n then.
  task automatic run(input int m, input int c2, input int m2, input int abort_c);
    bit aborted;
    aborted = 1'b0;
    for (int a = 0; a < W0; a++) cap[a] = '1;
    @(negedge clk);
    start = 1'b1;
    mode  = 2'(m);
    @(posedge clk);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      start = (c == c2);
      if (c2 > 0 && c >= c2) mode = 2'(m2);
      if (c == abort_c) begin
        rst_n = 1'b0;
        #1;
        check_idle("abort");
        aborted = 1'b1;
      end else if (aborted) begin
        if (c == abort_c + 2) rst_n = 1'b1;
        chk("abort_no_busy", 64'({b0, b1}), 64'd0);
        chk("abort_no_done", 64'({d0, d1}), 64'd0);
      end else begin
        check_dut("w2", c, W0, m, e0, a10, we0, a20, din0, b0, d0);
        check_dut("w1", c, W1, m, e1, a11, we1, a21, din1, b1, d1);
        if (we0) cap[a20] = din0;
`ifdef YS_POLY_SMALL_CYCCNT_EN
        if (c >= W0 + 4) chk("w2_cyc_cnt", 64'(cnt0), 64'(W0 + 3));
        if (c >= W1 + 4) chk("w1_cyc_cnt", 64'(cnt1), 64'(W1 + 3));
`endif
      end
    end
    start = 1'b0;
  endtask

  task automatic load(input logic [CWT-1:0] v0, v1, v2, v3, v4, v5, v6, v7);
    coef[0] = v0; coef[1] = v1; coef[2] = v2; coef[3] = v3;
    coef[4] = v4; coef[5] = v5; coef[6] = v6; coef[7] = v7;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    mode  = 2'd0;
    load(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Mode 3, coefficients 1..8: every output is 3*(-1)
    load(1, 2, 3, 4, 5, 6, 7, 8);
    run(3, 0, 0, 0);
    chk("lit_m3_w0", 64'(cap[0]), 64'({13'h1FFD, 13'h1FFD, 13'h1FFD, 13'h1FFD}));
    chk("lit_m3_w1", 64'(cap[1]), 64'({13'h1FFD, 13'h1FFD, 13'h1FFD, 13'h1FFD}));

    // Carry across the word boundary
    load(0, 0, 0, 13'h1FFF, 0, 0, 0, 0);
    run(3, 0, 0, 0);
    chk("lit_wrap_w0", 64'(cap[0]), 64'({13'd3, 13'd0, 13'd0, 13'd0}));
    chk("lit_wrap_w1", 64'(cap[1]), 64'({13'd0, 13'd0, 13'd0, 13'h1FFD}));

    load(5, 0, 13'h1FFF, 7, 9, 13'h1000, 2, 13'h1FFE);
    run(0, 0, 0, 0);
    chk("lit_copy_w0", 64'(cap[0]), 64'({13'd7, 13'h1FFF, 13'd0, 13'd5}));
    run(1, 0, 0, 0);
    chk("lit_neg_w0", 64'(cap[0]), 64'({13'h1FF9, 13'd1, 13'd0, 13'h1FFB}));
    run(2, 0, 0, 0);
    chk("lit_diff_w0", 64'(cap[0]), 64'({13'h1FF8, 13'd1, 13'd5, 13'h1FFB}));

    // Second start and mode change while busy: latched DIFF must persist
    run(2, 2, 1, 0);
    chk("lit_busy_start_w0", 64'(cap[0]), 64'({13'h1FF8, 13'd1, 13'd5, 13'h1FFB}));

    // Abort mid-run, then clean runs with a fresh carry
    load(1, 2, 3, 4, 5, 6, 7, 8);
    run(3, 0, 0, 2);
    run(1, 0, 0, 0);
    chk("lit_after_abort_w0", 64'(cap[0]), 64'({13'h1FFC, 13'h1FFD, 13'h1FFE, 13'h1FFF}));
    run(2, 0, 0, 0);
    chk("lit_carry_clear_w0", 64'(cap[0]), 64'({13'h1FFF, 13'h1FFF, 13'h1FFF, 13'h1FFF}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_ys_poly_small_stream
`default_nettype wire
